// File: rtl/img_conv_engine.sv
// rtl/img_conv_engine.sv - 3x3 streaming convolution engine with zero padding and line buffers
// Optional IMG_CONV_SAT_EN: clamp the shifted sum to the pixel range instead of wrapping.
module img_conv_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CH         = 1,
  parameter int MAX_WIDTH      = 1920,
  parameter int MAX_WIDTH_LOG2 = 11,
  parameter int COEF_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH*NUM_CH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tuser,
  input  logic                         s_axis_tlast,
  output logic [DATA_WIDTH*NUM_CH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  input  logic [MAX_WIDTH_LOG2:0]      cfg_width,
  input  logic [9*COEF_WIDTH-1:0]      cfg_weights,
  input  logic [3:0]                   cfg_shift,
  input  logic                         start,
  output logic                         run,
  output logic                         done,
  output logic                         err_line
);
  localparam int BEAT_W = DATA_WIDTH * NUM_CH;
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int SUM_W  = DATA_WIDTH + COEF_WIDTH + 5;
  localparam int CNT_W  = MAX_WIDTH_LOG2 + 1;
`ifdef IMG_CONV_SAT_EN
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << DATA_WIDTH) - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DRAIN} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          width_q;
  logic [CNT_W-1:0]          col;
  logic [9*COEF_WIDTH-1:0]   weights_q;
  logic [3:0]                shift_q;
  logic [1:0]                row_idx;
  logic                      tail;

  logic [BEAT_W-1:0]         lb0 [MAX_WIDTH];
  logic [BEAT_W-1:0]         lb1 [MAX_WIDTH];
  logic [3*BEAT_W-1:0]       col_a;
  logic [3*BEAT_W-1:0]       col_b;
  logic [3*BEAT_W-1:0]       col_new;
  logic [3*BEAT_W-1:0]       win [3];

  logic                      adv;
  logic                      in_row;
  logic                      at_end;
  logic                      take;
  logic                      step;
  logic                      step_out;
  logic [MAX_WIDTH_LOG2-1:0] lb_idx;
  logic [BEAT_W-1:0]         pix_in;
  logic [BEAT_W-1:0]         top_rd;
  logic [BEAT_W-1:0]         mid_rd;

  logic signed [PROD_W-1:0]  prod [NUM_CH][9];
  logic signed [SUM_W-1:0]   acc;
  logic [BEAT_W-1:0]         sum_res;
  logic [BEAT_W-1:0]         data2;
  logic                      v1, u1, l1, v2, u2, l2;

  function automatic logic signed [PROD_W-1:0] mul(input logic [DATA_WIDTH-1:0] p,
                                                   input logic [COEF_WIDTH-1:0] w);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = {{COEF_WIDTH{1'b0}}, p};
    b = {{DATA_WIDTH{w[COEF_WIDTH-1]}}, w};
    return a * b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] post(input logic signed [SUM_W-1:0] sum,
                                                 input logic [3:0] sh);
`ifdef IMG_CONV_SAT_EN
    logic signed [SUM_W-1:0] s;
    s = sum >>> sh;
    if (s[SUM_W-1]) return '0;
    if (s > PIX_MAX) return '1;
    return s[DATA_WIDTH-1:0];
`else
    return DATA_WIDTH'(sum >>> sh);
`endif
  endfunction

  // The whole pipeline moves only when the output register can hand off its beat.
  always_comb begin
    adv           = !m_axis_tvalid || m_axis_tready;
    in_row        = (state == S_FILL) || (state == S_STREAM);
    at_end        = (col == width_q);
    s_axis_tready = in_row && !at_end && adv;
    take          = s_axis_tready && s_axis_tvalid;
    step          = take || (adv && ((in_row && at_end) || (state == S_FLUSH)));
    step_out      = step && (row_idx != 2'd0) && (col != '0);
    lb_idx        = at_end ? '0 : col[MAX_WIDTH_LOG2-1:0];
    top_rd        = lb1[lb_idx];
    mid_rd        = lb0[lb_idx];
    pix_in        = take ? s_axis_tdata : '0;
    // New right-hand column: bottom is the incoming row, rows above come from the line buffers.
    col_new       = {pix_in,
                     (row_idx != 2'd0 && !at_end) ? mid_rd : {BEAT_W{1'b0}},
                     (row_idx == 2'd2 && !at_end) ? top_rd : {BEAT_W{1'b0}}};
    win[0]        = col_a;
    win[1]        = col_b;
    win[2]        = col_new;
  end

  always_comb begin
    sum_res = '0;
    acc     = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      acc = '0;
      for (int k = 0; k < 9; k++) begin
        acc = acc + {{(SUM_W-PROD_W){prod[ch][k][PROD_W-1]}}, prod[ch][k]};
      end
      sum_res[ch*DATA_WIDTH +: DATA_WIDTH] = post(acc, shift_q);
    end
  end

  always_ff @(posedge clk) begin
    if (step) begin
      if (!at_end) begin
        lb1[lb_idx] <= mid_rd;
        lb0[lb_idx] <= pix_in;
      end
      col_a <= (col == '0) ? '0 : col_b;
      col_b <= col_new;
    end
    if (adv) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        for (int k = 0; k < 9; k++) begin
          prod[ch][k] <= mul(win[k%3][(k/3)*BEAT_W + ch*DATA_WIDTH +: DATA_WIDTH],
                             weights_q[k*COEF_WIDTH +: COEF_WIDTH]);
        end
      end
      data2        <= sum_res;
      m_axis_tdata <= data2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; u1 <= 1'b0; l1 <= 1'b0;
      v2 <= 1'b0; u2 <= 1'b0; l2 <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (adv) begin
      v1            <= step_out;
      u1            <= step_out && at_end;
      l1            <= step_out && at_end && (state == S_FLUSH) && !tail;
      v2            <= v1;
      u2            <= u1;
      l2            <= l1;
      m_axis_tvalid <= v2;
      m_axis_tuser  <= u2;
      m_axis_tlast  <= l2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      run       <= 1'b0;
      done      <= 1'b0;
      err_line  <= 1'b0;
      col       <= '0;
      row_idx   <= 2'd0;
      tail      <= 1'b0;
      width_q   <= '0;
      weights_q <= '0;
      shift_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_width == '0 || cfg_width > CNT_W'(MAX_WIDTH)) begin
              err_line <= 1'b1;
            end else begin
              width_q   <= cfg_width;
              weights_q <= cfg_weights;
              shift_q   <= cfg_shift;
              err_line  <= 1'b0;
              run       <= 1'b1;
              col       <= '0;
              row_idx   <= 2'd0;
              tail      <= 1'b0;
              state     <= S_FILL;
            end
          end
        end
        S_FILL, S_STREAM, S_FLUSH: begin
          if (step) begin
            if (take && (s_axis_tuser != (col == width_q - 1'b1))) err_line <= 1'b1;
            if (at_end) begin
              col <= '0;
              if (row_idx != 2'd2) row_idx <= row_idx + 2'd1;
              if (state == S_FILL) state <= S_STREAM;
              // In FLUSH, tail marks the bubble that still closes the last input row.
              if (state == S_FLUSH) begin
                if (tail) tail <= 1'b0;
                else      state <= S_DRAIN;
              end
            end else begin
              col <= col + 1'b1;
            end
            if (take && s_axis_tlast) begin
              state <= S_FLUSH;
              tail  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            done  <= 1'b1;
            run   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_img_conv_engine.sv
// tb/tb_img_conv_engine.sv - self-checking bench for img_conv_engine against a direct 3x3 convolution model
module tb_img_conv_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [11:0] cfg_width = '0;
  logic [35:0] cfg_weights = '0;
  logic [3:0]  cfg_shift = '0;
  logic        start = 1'b0;
  logic        run, done, err_line;

  int checks = 0;
  int failures = 0;
  int img [16][16];
  int wt [9];
  int sh = 0;
  bit bp_en = 1'b0;
  logic [9:0] exp_q [$];
  logic [9:0] got_q [$];
  logic       hold_v = 1'b0;
  logic [9:0] hold_beat = '0;

  img_conv_engine dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .cfg_width(cfg_width), .cfg_weights(cfg_weights), .cfg_shift(cfg_shift),
    .start(start), .run(run), .done(done), .err_line(err_line)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Expected beat straight from the definition: zero-padded 3x3 sum, shift, then clamp or wrap.
  function automatic logic [9:0] model_beat(input int r, input int c, input int w, input int h);
    int a;
    a = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (r + dy >= 0 && r + dy < h && c + dx >= 0 && c + dx < w)
          a += img[r+dy][c+dx] * wt[(dy+1)*3 + dx + 1];
    a = a >>> sh;
`ifdef IMG_CONV_SAT_EN
    if (a < 0) a = 0;
    else if (a > 255) a = 255;
`endif
    return {(r == h-1 && c == w-1), (c == w-1), 8'(a & 255)};
  endfunction

  always @(negedge clk) begin
    logic [9:0] beat;
    logic [9:0] want;
    beat = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!m_axis_tvalid || beat !== hold_beat) begin
          failures++;
          $display("FAIL stable_hold got v=%0b beat=%h want v=1 beat=%h", m_axis_tvalid, beat, hold_beat);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(beat);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat got=%h want=none", beat);
        end else begin
          want = exp_q.pop_front();
          if (beat !== want) begin
            failures++;
            $display("FAIL beat got=%h want=%h", beat, want);
          end
        end
        hold_v = 1'b0;
      end else if (m_axis_tvalid) begin
        hold_v    = 1'b1;
        hold_beat = beat;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  function automatic logic [35:0] pack_w();
    logic [35:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[k*4 +: 4] = 4'(wt[k]);
    return p;
  endfunction

  task automatic set_kernel(input int center_only, input int v);
    for (int k = 0; k < 9; k++) wt[k] = center_only ? ((k == 4) ? v : 0) : v;
  endtask

  task automatic start_frame(input int w, input int h);
    exp_q.delete();
    got_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) exp_q.push_back(model_beat(r, c, w, h));
    cfg_width   = 12'(w);
    cfg_weights = pack_w();
    cfg_shift   = 4'(sh);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("run_after_start", int'(run), 1);
  endtask

  task automatic feed_frame(input int w, input int h, input int ucol);
    bit acc;
    int n;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        s_axis_tdata  = 8'(img[r][c]);
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = (ucol >= 0) ? (c == ucol) : (c == w-1);
        s_axis_tlast  = (r == h-1 && c == w-1);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 1000) begin
          @(negedge clk);
          acc = s_axis_tready;
          @(posedge clk);
          #1;
          n++;
        end
        if (!acc) check("feed_timeout", 0, 1);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check({name, "_done"}, int'(seen), 1);
    @(negedge clk);
    check({name, "_done_pulse_run"}, int'({done, run}), 0);
    check({name, "_beats_left"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input string name, input int w, input int h, input int ucol);
    start_frame(w, h);
    feed_frame(w, h, ucol);
    wait_done(name);
  endtask

  task automatic lit(input string name, input int idx, input int want);
    if (idx < got_q.size()) check(name, int'(got_q[idx][7:0]), want);
    else check({name, "_missing"}, got_q.size(), idx + 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({run, done, err_line, m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_axis_tready}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity kernel on a 4x3 ramp: outputs reproduce the input with row-end and frame-end flags.
    set_kernel(1, 1); sh = 0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) img[r][c] = r*4 + c + 1;
    do_frame("ident", 4, 3, -1);
    check("ident_count", got_q.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < got_q.size())
        check("ident_lit", int'(got_q[i]), ((i == 11) ? 512 : 0) + ((i % 4 == 3) ? 256 : 0) + i + 1);
    check("ident_err_line", int'(err_line), 0);

    // Single-row frame: every output comes from the flush row.
    set_kernel(0, 1); sh = 1;
    for (int c = 0; c < 5; c++) img[0][c] = 20 * c + 7;
    do_frame("one_row", 5, 1, -1);
    check("one_row_count", got_q.size(), 5);
    lit("one_row_c0", 0, 17);

    // All-ones kernel on flat frames.
    set_kernel(0, 1); sh = 0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img[r][c] = 10;
    do_frame("ones10", 3, 3, -1);
    lit("ones10_corner", 0, 40);
    lit("ones10_edge", 1, 60);
    lit("ones10_centre", 4, 90);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img[r][c] = 100;
    do_frame("ones100", 3, 3, -1);
`ifdef IMG_CONV_SAT_EN
    lit("ones100_centre_sat", 4, 255);
    lit("ones100_corner_sat", 0, 255);
`else
    lit("ones100_centre_wrap", 4, 132);
    lit("ones100_corner_wrap", 0, 144);
`endif
    set_kernel(1, -1);
    do_frame("neg", 3, 3, -1);
`ifdef IMG_CONV_SAT_EN
    lit("neg_sat", 4, 0);
`else
    lit("neg_wrap", 4, 156);
`endif

    // Random 16x8 frame, random kernel and shift, 50 % output backpressure.
    for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) img[r][c] = int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) wt[k] = int'($urandom_range(0, 15)) - 8;
    sh = int'($urandom_range(0, 3));
    bp_en = 1'b1;
    do_frame("random", 16, 8, -1);
    bp_en = 1'b0;
    check("random_count", got_q.size(), 128);
    check("random_err_line", int'(err_line), 0);

    // Illegal widths are rejected at start.
    cfg_width = 12'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("width0_err_run", int'({err_line, run, s_axis_tready}), 4);
    @(posedge clk); #1;
    cfg_width = 12'd1921; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("width1921_err_run", int'({err_line, run}), 2);
    @(posedge clk); #1;

    // Misplaced end-of-line marker: error flagged, frame still complete.
    set_kernel(1, 1); sh = 0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) img[r][c] = 3*r + 5*c + 1;
    do_frame("tuser_err", 4, 3, 2);
    check("tuser_err_line", int'(err_line), 1);
    check("tuser_err_count", got_q.size(), 12);

    // Asynchronous reset during FLUSH, then a clean frame.
    start_frame(4, 3);
    feed_frame(4, 3, -1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_flush", int'({run, done, err_line, m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_axis_tready}), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_axis_tvalid) n++;
    end
    check("post_rst_idle", int'({run, s_axis_tready}), 0);
    check("post_rst_no_beats", n, 0);
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) img[r][c] = 200 - 9*(r*4 + c);
    do_frame("after_rst", 4, 3, -1);
    lit("after_rst_first", 0, 200);
    lit("after_rst_last", 11, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
